// File: rtl/muldiv_unit_if.sv
// Handshake and data bundle between the pipeline and muldiv_unit.
// The master side issues operations and HI/LO moves; the slave side is the unit.
interface muldiv_unit_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        flush;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   modport master (
      output start, op, A, B, flush, mthi, mtlo, wdata,
      input  hi, lo, busy, done
   );

   modport slave (
      input  start, op, A, B, flush, mthi, mtlo, wdata,
      output hi, lo, busy, done
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit holding the architectural HI/LO registers.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle mult/multu; divides stay 32-step.
module muldiv_unit (
   input  logic          clk,
   input  logic          rst_n,
   muldiv_unit_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state, stateNext;
   logic [4:0]  count;
   logic [1:0]  opReg;
   logic [31:0] aReg, bReg, mag, hiReg, loReg;
   logic [63:0] acc, stepAcc;
   logic        accept, busyC, doneC, lastStep, fastMul;
   logic        isDiv, signedOp, negQ, negR;
   logic [32:0] addSum, shifted;
   logic [33:0] trial;
   logic [63:0] prod;
   logic [31:0] resHi, resLo, absA, absB;

   // Operands are reduced to magnitudes on acceptance; signs are restored at the final step.
   assign absA = (~bus.op[0] && bus.A[31]) ? -bus.A : bus.A;
   assign absB = (~bus.op[0] && bus.B[31]) ? -bus.B : bus.B;

   assign isDiv    = opReg[1];
   assign signedOp = ~opReg[0];

   // acc holds {partial product} for multiply and {remainder, quotient} for divide.
   assign addSum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? mag : 32'd0)};
   assign shifted = {acc[63:32], acc[31]};
   assign trial   = {1'b0, shifted} - {2'b00, mag};

`ifdef MULDIV_FAST_MUL_EN
   assign fastMul = ~isDiv;
   always_comb begin
      stepAcc = {32'd0, mag} * {32'd0, acc[31:0]};
      if (isDiv)
         stepAcc = trial[33] ? {shifted[31:0], acc[30:0], 1'b0}
                             : {trial[31:0], acc[30:0], 1'b1};
   end
`else
   assign fastMul = 1'b0;
   assign stepAcc = isDiv ? (trial[33] ? {shifted[31:0], acc[30:0], 1'b0}
                                       : {trial[31:0], acc[30:0], 1'b1})
                          : {addSum, acc[31:1]};
`endif

   assign lastStep = (count == 5'd31) || fastMul;

   assign negQ = signedOp && (aReg[31] ^ bReg[31]);
   assign negR = signedOp && aReg[31];
   assign prod = negQ ? -stepAcc : stepAcc;

   always_comb begin
      resHi = prod[63:32];
      resLo = prod[31:0];
      if (isDiv) begin
         if (bReg == 32'd0) begin
            resHi = aReg;
            resLo = 32'hFFFF_FFFF;
         end else begin
            resHi = negR ? -stepAcc[63:32] : stepAcc[63:32];
            resLo = negQ ? -stepAcc[31:0]  : stepAcc[31:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   // A start is honoured only outside CALC and only when not cancelled by flush.
   always_comb begin
      stateNext = state;
      accept    = 1'b0;
      busyC     = 1'b0;
      doneC     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && !bus.flush) begin
               accept    = 1'b1;
               stateNext = CALC;
            end
         end
         CALC: begin
            busyC = 1'b1;
            if (bus.flush)     stateNext = IDLE;
            else if (lastStep) stateNext = DONE;
         end
         DONE: begin
            doneC = 1'b1;
            if (bus.start && !bus.flush) begin
               accept    = 1'b1;
               stateNext = CALC;
            end else begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 5'd0;
         opReg <= 2'd0;
         aReg  <= 32'd0;
         bReg  <= 32'd0;
         mag   <= 32'd0;
         acc   <= 64'd0;
         hiReg <= 32'd0;
         loReg <= 32'd0;
      end else if (accept) begin
         count <= 5'd0;
         opReg <= bus.op;
         aReg  <= bus.A;
         bReg  <= bus.B;
         mag   <= bus.op[1] ? absB : absA;
         acc   <= {32'd0, (bus.op[1] ? absA : absB)};
      end else if (state == CALC) begin
         if (!bus.flush) begin
            acc   <= stepAcc;
            count <= count + 5'd1;
            if (lastStep) begin
               hiReg <= resHi;
               loReg <= resLo;
            end
         end
      end else begin
         if (bus.mthi) hiReg <= bus.wdata;
         if (bus.mtlo) loReg <= bus.wdata;
      end
   end

   assign bus.hi   = hiReg;
   assign bus.lo   = loReg;
   assign bus.busy = busyC;
   assign bus.done = doneC;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed steps, scoreboard of expected HI/LO,
// flush, mid-operation reset and back-to-back issue with a blocked mtlo.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   muldiv_unit_if bus();
   muldiv_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          busyCycles;
   } exp_t;

   exp_t        sb[$];
   int          compared = 0;
   int          mismatched = 0;
   logic [31:0] modelHi = 32'd0;
   logic [31:0] modelLo = 32'd0;

   // Reference behaviour built from plain SV arithmetic on the raw operands.
   function automatic exp_t model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
      exp_t        e;
      logic [63:0] p;
      longint      sa, sb2;
      int          q, r;
      sa  = longint'($signed(a));
      sb2 = longint'($signed(b));
      p   = 64'd0;
      case (op)
         2'b00: p = sa * sb2;
         2'b01: p = {32'd0, a} * {32'd0, b};
         2'b10: begin
            if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
            else begin
               q = $signed(a) / $signed(b);
               r = $signed(a) % $signed(b);
               p = {r, q};
            end
         end
         default: begin
            if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
            else            p = {a % b, a / b};
         end
      endcase
      e.hi = p[63:32];
      e.lo = p[31:0];
`ifdef MULDIV_FAST_MUL_EN
      e.busyCycles = op[1] ? 32 : 1;
`else
      e.busyCycles = 32;
`endif
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Call at a negedge; returns at the negedge following the accepting edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input bit track);
      bus.op    = op;
      bus.A     = a;
      bus.B     = b;
      bus.start = 1'b1;
      if (track) sb.push_back(model(op, a, b));
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Waits for done, then compares HI/LO and the busy length against the scoreboard head.
   task automatic checkOutput(input string tag, input int alreadyBusy);
      exp_t e;
      int   n = alreadyBusy;
      int   guard = 0;
      while (bus.done !== 1'b1 && guard < 100) begin
         if (bus.busy === 1'b1) n++;
         guard++;
         @(negedge clk);
      end
      check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
      if (sb.size() == 0) begin
         check({tag, "_sb"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, "_hi"}, bus.hi, e.hi);
         check({tag, "_lo"}, bus.lo, e.lo);
         check({tag, "_busy"}, n, e.busyCycles);
         modelHi = e.hi;
         modelLo = e.lo;
      end
   endtask

   logic [1:0]  dirOp [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11};
   logic [31:0] dirA  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7,
                              32'h8000_0000, 32'hDEAD_BEEF};
   logic [31:0] dirB  [6] = '{32'd2, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd13};

   initial begin
      bit sawDone;
      bus.start = 1'b0; bus.op = 2'b00; bus.A = 32'd0; bus.B = 32'd0;
      bus.flush = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = 32'd0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_hi", bus.hi, 32'd0);
      check("rst_lo", bus.lo, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] directed operations");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(dirOp[i], dirA[i], dirB[i], 1'b1);
         checkOutput($sformatf("dir%0d", i), 0);
         @(negedge clk);
         check($sformatf("dir%0d_pulse", i), {31'd0, bus.done}, 32'd0);
      end

      $display("[TB] random operations");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(2'($urandom_range(0, 3)), $urandom, (i == 5) ? 32'd3 : $urandom, 1'b1);
         checkOutput($sformatf("rnd%0d", i), 0);
         @(negedge clk);
      end

      $display("[TB] mthi then flushed divide");
      bus.mthi = 1'b1; bus.wdata = 32'h1234_5678;
      @(negedge clk);
      bus.mthi = 1'b0;
      modelHi = 32'h1234_5678;
      check("mthi_hi", bus.hi, modelHi);
      applyStimulus(2'b10, 32'd100, 32'd7, 1'b0);
      repeat (9) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush_busy", {31'd0, bus.busy}, 32'd0);
      check("flush_hi", bus.hi, modelHi);
      check("flush_lo", bus.lo, modelLo);
      sawDone = 1'b0;
      repeat (40) begin
         if (bus.done === 1'b1) sawDone = 1'b1;
         @(negedge clk);
      end
      check("flush_nodone", {31'd0, sawDone}, 32'd0);

      $display("[TB] start cancelled by flush, paired mthi/mtlo");
      bus.start = 1'b1; bus.flush = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      check("cancel_busy", {31'd0, bus.busy}, 32'd0);
      bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hA5A5_5A5A;
      @(negedge clk);
      bus.mthi = 1'b0; bus.mtlo = 1'b0;
      modelHi = 32'hA5A5_5A5A; modelLo = 32'hA5A5_5A5A;
      check("mtboth_hi", bus.hi, modelHi);
      check("mtboth_lo", bus.lo, modelLo);

      $display("[TB] back-to-back with blocked mtlo");
      bus.mtlo = 1'b1; bus.wdata = 32'h0BAD_F00D;
      applyStimulus(2'b11, 32'd1000, 32'd7, 1'b1);
      bus.mtlo = 1'b0;
      check("mtlo_start_lo", bus.lo, modelLo);
      repeat (3) @(negedge clk);
      bus.mtlo = 1'b1; bus.wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.mtlo = 1'b0;
      check("mtlo_calc_lo", bus.lo, modelLo);
      checkOutput("b2b_first", 4);
      applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b1);
      check("b2b_noidle", {31'd0, bus.busy}, 32'd1);
      checkOutput("b2b_second", 0);
      @(negedge clk);

      $display("[TB] reset during divide");
      applyStimulus(2'b11, 32'd5000, 32'd3, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rstmid_hi", bus.hi, 32'd0);
      check("rstmid_lo", bus.lo, 32'd0);
      check("rstmid_busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      sawDone = 1'b0;
      repeat (40) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) sawDone = 1'b1;
         @(negedge clk);
      end
      check("rstmid_quiet", {31'd0, sawDone}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
